// File: rtl/scan_pkg.sv
// Shared FSM state and chain-select encodings for the scan chain unload controller.
package scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_DRAIN
  } state_t;

  localparam logic SD_CAPTURE = 1'b0;
  localparam logic SD_SHIFT   = 1'b1;

endpackage

// File: rtl/scan_word_packer.sv
// Serial-in, LSB-first word collector with a single output register on a valid/ready port.
// A completed word that cannot move to the output register is held in the collector as pending.
module scan_word_packer
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 4
) (
  input  logic              CK,
  input  logic              CD,
  input  logic              sample_en,
  input  logic              sample_bit,
  input  logic              out_ready,
  output logic              pending_nxt,
  output logic              final_sample,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(WORD_W + 1);

  logic [BW-1:0]     bit_cnt;
  logic [IW-1:0]     idx;
  logic [WORD_W-1:0] col;
  logic [WORD_W-1:0] col_nxt;
  logic              pending;
  logic              pend_last;
  logic              word_done;
  logic              out_free;

  always_comb begin
    out_free     = !out_valid || out_ready;
    final_sample = sample_en && (bit_cnt == BW'(CHAIN_LEN - 1));
    word_done    = sample_en && ((idx == IW'(WORD_W - 1)) || final_sample);
    col_nxt      = col | (WORD_W'(sample_bit) << idx);
    // Lets the controller register chain_sp low in the same cycle a word becomes stuck.
    pending_nxt  = !out_free && (pending || word_done);
  end

  always_ff @(posedge CK) begin
    if (CD) begin
      bit_cnt   <= '0;
      idx       <= '0;
      col       <= '0;
      pending   <= 1'b0;
      pend_last <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (sample_en) begin
        bit_cnt <= final_sample ? '0 : bit_cnt + BW'(1);
        if (word_done) begin
          idx <= '0;
          if (out_free) begin
            out_data  <= col_nxt;
            out_valid <= 1'b1;
            out_last  <= final_sample;
            col       <= '0;
          end else begin
            col       <= col_nxt;
            pending   <= 1'b1;
            pend_last <= final_sample;
          end
        end else begin
          col <= col_nxt;
          idx <= idx + IW'(1);
        end
      end else if (pending && out_free) begin
        out_data  <= col;
        out_valid <= 1'b1;
        out_last  <= pend_last;
        col       <= '0;
        pending   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_chain_reader.sv
// Unload controller for one load-mux scan chain: capture functional state once,
// shift the chain out serially, and hand packed words to a valid/ready consumer.
module scan_chain_reader
  import scan_pkg::*;
#(
  parameter int   CHAIN_LEN = 8,
  parameter int   WORD_W    = 4,
  parameter logic FILL      = 1'b0
) (
  input  logic              CK,
  input  logic              CD,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              chain_sp,
  output logic              chain_sd,
  output logic              chain_si,
  input  logic              chain_so,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  state_t state;
  logic   sample_en;
  logic   pending_nxt;
  logic   final_sample;

  assign chain_si  = FILL;
  assign sample_en = chain_sp && (chain_sd == SD_SHIFT);

  scan_word_packer #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) u_packer (
    .CK          (CK),
    .CD          (CD),
    .sample_en   (sample_en),
    .sample_bit  (chain_so),
    .out_ready   (out_ready),
    .pending_nxt (pending_nxt),
    .final_sample(final_sample),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last)
  );

  always_ff @(posedge CK) begin
    if (CD) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      chain_sp <= 1'b0;
      chain_sd <= SD_CAPTURE;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CAPTURE;
            busy     <= 1'b1;
            chain_sp <= 1'b1;
            chain_sd <= SD_CAPTURE;
          end
        end
        S_CAPTURE: begin
          state    <= S_SHIFT;
          chain_sp <= 1'b1;
          chain_sd <= SD_SHIFT;
        end
        S_SHIFT: begin
          if (final_sample) begin
            state    <= S_DRAIN;
            chain_sp <= 1'b0;
          end else begin
            chain_sp <= !pending_nxt;
          end
        end
        S_DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            chain_sd <= SD_CAPTURE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
